// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered read port and registered status flags.
// Also provides one-cycle overflow/underflow pulses for rejected requests.
module sync_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           din,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       ovf,
   output logic                       unf
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];

   logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
   logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
   logic [AW:0]      count_reg, count_next;
   logic [WIDTH-1:0] dout_reg, dout_next;
   logic             full_reg, full_next;
   logic             empty_reg, empty_next;
   logic             ovf_reg, ovf_next;
   logic             unf_reg, unf_next;
   logic             wr_acc, rd_acc;

   always_comb begin
      rd_acc      = rd_en && !empty_reg;
      // A read in the same cycle frees a slot, so a full FIFO still takes the write.
      wr_acc      = wr_en && (!full_reg || rd_acc);

      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      dout_next   = dout_reg;

      if (wr_acc) begin
         wr_ptr_next = wr_ptr_reg + AW'(1);
      end
      if (rd_acc) begin
         rd_ptr_next = rd_ptr_reg + AW'(1);
         dout_next   = mem[rd_ptr_reg];
      end

      count_next = count_reg + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
      full_next  = (count_next == (AW+1)'(DEPTH));
      empty_next = (count_next == '0);
      ovf_next   = wr_en && !wr_acc;
      unf_next   = rd_en && !rd_acc;
   end

   // Storage carries no reset; entries are meaningless until written.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr_reg] <= din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         dout_reg   <= '0;
         full_reg   <= 1'b0;
         empty_reg  <= 1'b1;
         ovf_reg    <= 1'b0;
         unf_reg    <= 1'b0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
         dout_reg   <= dout_next;
         full_reg   <= full_next;
         empty_reg  <= empty_next;
         ovf_reg    <= ovf_next;
         unf_reg    <= unf_next;
      end
   end

   assign dout  = dout_reg;
   assign full  = full_reg;
   assign empty = empty_reg;
   assign count = count_reg;
   assign ovf   = ovf_reg;
   assign unf   = unf_reg;

endmodule
